alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for an external 4-bit ALU: loads an accumulator, issues one ALU
// operation per command, captures the result and holds it until the consumer takes it.
module alu_sequencer #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_load,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_ctrl0,
  output logic              alu_ctrl1,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_ovf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ovf,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_CMP = 2'b11;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_reg;
  logic [1:0]        op_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    alu_a      = acc;
    alu_b      = '0;
    alu_ctrl0  = 1'b0;
    alu_ctrl1  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && !cmd_load) state_next = EXEC;
      end
      EXEC: begin
        alu_b      = b_reg;
        alu_ctrl0  = op_reg[0];
        alu_ctrl1  = op_reg[1];
        state_next = RESP;
      end
      RESP: begin
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
      op_count   <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        if (cmd_load) begin
          acc <= cmd_data;
        end else begin
          op_reg <= cmd_op;
          b_reg  <= cmd_data;
        end
      end
      // Result capture; compare reports A > B without disturbing the accumulator.
      if (state == EXEC) begin
        res_data  <= alu_c;
        res_ovf   <= alu_ovf;
        res_valid <= 1'b1;
        if (op_reg != OP_CMP) acc <= alu_c;
      end
      if (state == RESP && res_ready) begin
        res_valid <= 1'b0;
        op_count  <= op_count + 8'd1;
      end
      if (state == EXEC && alu_ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky)          ovf_sticky <= 1'b0;
    end
  end

endmodule
